mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, memory address width in bits.
REQ-002 Parameter DATA_W, default 32, memory data width in bits; byte-enable width is DATA_W/8.
REQ-003 Parameter STARVE_MAX, default 8, number of consecutive fetch losses before fetch is forced to win (4-bit counter).
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 if_req / if_addr  in  1 / ADDR_W  instruction-fetch read request and its address.
REQ-007 if_gnt / if_rvalid / if_rdata  out  1 / 1 / DATA_W  fetch grant pulse, read-valid pulse, and read data.
REQ-008 dm_req / dm_we / dm_addr / dm_wdata / dm_be  in  1 / 1 / ADDR_W / DATA_W / DATA_W/8  data-memory request, write flag, address, write data and byte enables.
REQ-009 dm_gnt / dm_rvalid / dm_rdata  out  1 / 1 / DATA_W  data grant pulse, read-valid pulse, and read data.
REQ-010 mem_req / mem_we / mem_addr / mem_wdata / mem_be  out  1 / 1 / ADDR_W / DATA_W / DATA_W/8  request to the shared single-port memory.
REQ-011 mem_gnt / mem_rvalid / mem_rdata  in  1 / 1 / DATA_W  memory grant, read-valid, and read data.
REQ-012 stall_if / stall_mem  out  1 / 1  stall requests to the hazard control unit, freezing the fetch stage and the MEM stage respectively.

Function
REQ-013 The block SHALL implement an FSM with states IDLE, WAIT_GNT and WAIT_R, and SHALL allow at most one outstanding transaction.
REQ-014 IDLE, arbitration: with only one request pending, that requester SHALL be selected; with both pending, data SHALL win unless the starvation counter is at or above STARVE_MAX, in which case fetch SHALL win.
REQ-015 IDLE, issue: mem_req and the mem_* fields SHALL be driven combinationally from the selected requester in the same cycle (zero-cycle issue); the owner and all request fields SHALL be registered.
REQ-016 IDLE and WAIT_GNT, mem_gnt=1: the owner's gnt SHALL pulse for exactly one cycle; next state SHALL be WAIT_R for a read and IDLE for a write.
REQ-017 IDLE, mem_gnt=0 with a request issued: next state SHALL be WAIT_GNT, and mem_* SHALL hold the latched values regardless of further requester input changes.
REQ-018 WAIT_R: mem_req SHALL be 0; on mem_rvalid=1 the owner's rvalid SHALL pulse, its rdata SHALL equal mem_rdata in the same cycle, and next state SHALL be IDLE.
REQ-019 No new request SHALL be accepted in the cycle rvalid is returned; this gives one bubble cycle per read.
REQ-020 mem_rvalid SHALL be ignored in IDLE and WAIT_GNT; if_rdata and dm_rdata are don't-care when their rvalid is 0.
REQ-021 stall_if SHALL equal if_req AND NOT if_rvalid.
REQ-022 stall_mem SHALL equal dm_req AND NOT done, where done is dm_gnt for a write and dm_rvalid for a read.
REQ-023 Starvation counter: +1 (saturating at 15) in each IDLE cycle where if_req=1 and data is selected; cleared when fetch is granted.

Reset
REQ-024 rst_n=0 SHALL asynchronously force the FSM to IDLE, clear the owner, latched fields and starvation counter, and drive all gnt/rvalid/mem_req/stall outputs to 0.
REQ-025 A reset asserted mid-transaction SHALL abandon that transaction; a late mem_rvalid arriving after release SHALL be dropped per REQ-020.

Configuration
REQ-026 Macro ARB_STARVE_EN: when defined, the starvation counter and fetch-forced priority (REQ-014, REQ-023) SHALL be present.
REQ-027 When ARB_STARVE_EN is undefined, priority SHALL be fixed with data over fetch, and no counter SHALL be synthesised.

Structure
REQ-028 The FSM state enum (arb_state_t) and the owner enum (OWN_IF, OWN_DM) SHALL live in my_pkg.
REQ-029 The STARVE_MAX default constant SHALL also live in my_pkg.
REQ-030 The block SHALL be a single module with no sub-modules.

Verification
REQ-031 Fetch only: if_addr=0x100, mem_gnt=1 in the same cycle, mem_rvalid 2 cycles later with 0x00000013 -> if_gnt in cycle 0, if_rvalid with if_rdata=0x13 in cycle 2, stall_if high during cycles 0-1.
REQ-032 Simultaneous requests: if_req and a dm_req read of 0x2000 -> 0x2000 issued first, dm_rvalid returned, then fetch issued one cycle after the bubble.
REQ-033 Write with mem_gnt held low for 3 cycles: dm_we=1, dm_be=0xF, dm_wdata=0xDEADBEEF -> mem_* stable for all 3 cycles, dm_gnt on the 4th cycle, return to IDLE with no rvalid.
REQ-034 Starvation (ARB_STARVE_EN defined): continuous dm_req plus if_req -> fetch granted once the counter reaches 8; without the macro, fetch is never granted while dm_req stays high.
REQ-035 Reset mid-operation: rst_n pulsed low in WAIT_R, then mem_rvalid=1 after release -> no if_rvalid/dm_rvalid, FSM in IDLE, all outputs 0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory-port arbiter: FSM states, owner
// encoding and the default starvation threshold.
package my_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GNT = 2'd1,
    WAIT_R   = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  localparam int unsigned STARVE_MAX_DEFAULT = 8;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one single-port memory,
// one transaction in flight. Build macro ARB_STARVE_EN adds fetch anti-starvation.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// IDLE     | no transaction; selected request is issued to memory this cycle
// WAIT_GNT | request issued, memory has not granted; mem_* held from latches
// WAIT_R   | read granted, waiting for mem_rvalid to return data to owner
module mem_port_arbiter
  import my_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,

  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic                dm_gnt,
  output logic                dm_rvalid,
  output logic [DATA_W-1:0]   dm_rdata,

  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,

  output logic                stall_if,
  output logic                stall_mem
);

  localparam int unsigned BE_W = DATA_W / 8;

  arb_state_t          state_q, state_d;
  owner_t              owner_q, cur_owner, sel_owner;
  logic                lat_we_q;
  logic [ADDR_W-1:0]   lat_addr_q;
  logic [DATA_W-1:0]   lat_wdata_q;
  logic [BE_W-1:0]     lat_be_q;
  logic                issue;
  logic                starve_force;

  assign issue     = (state_q == IDLE) && (if_req || dm_req);
  assign sel_owner = (if_req && (!dm_req || starve_force)) ? OWN_IF : OWN_DM;

  always_comb begin
    state_d   = state_q;
    cur_owner = owner_q;
    mem_req   = 1'b0;
    mem_we    = lat_we_q;
    mem_addr  = lat_addr_q;
    mem_wdata = lat_wdata_q;
    mem_be    = lat_be_q;
    if_gnt    = 1'b0;
    dm_gnt    = 1'b0;
    if_rvalid = 1'b0;
    dm_rvalid = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          cur_owner = sel_owner;
          mem_req   = 1'b1;
          if (sel_owner == OWN_IF) begin
            mem_we    = 1'b0;
            mem_addr  = if_addr;
            mem_wdata = '0;
            mem_be    = '1;
          end else begin
            mem_we    = dm_we;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
            mem_be    = dm_be;
          end
          if (mem_gnt) state_d = mem_we ? IDLE : WAIT_R;
          else         state_d = WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        mem_req = 1'b1;
        if (mem_gnt) state_d = lat_we_q ? IDLE : WAIT_R;
      end
      WAIT_R: begin
        if (mem_rvalid) begin
          state_d = IDLE;
          if (owner_q == OWN_IF) if_rvalid = 1'b1;
          else                   dm_rvalid = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (mem_req && mem_gnt) begin
      if (cur_owner == OWN_IF) if_gnt = 1'b1;
      else                     dm_gnt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      lat_be_q    <= '0;
    end else begin
      state_q <= state_d;
      if (issue) begin
        owner_q     <= cur_owner;
        lat_we_q    <= mem_we;
        lat_addr_q  <= mem_addr;
        lat_wdata_q <= mem_wdata;
        lat_be_q    <= mem_be;
      end
    end
  end

  // Read data is shared; each requester qualifies it with its own rvalid.
  assign if_rdata  = mem_rdata;
  assign dm_rdata  = mem_rdata;
  assign stall_if  = if_req && !if_rvalid;
  assign stall_mem = dm_req && !(dm_we ? dm_gnt : dm_rvalid);

`ifdef ARB_STARVE_EN
  logic [3:0] starve_cnt_q;

  assign starve_force = (32'(starve_cnt_q) >= STARVE_MAX);

  // Counts IDLE cycles where a waiting fetch lost to data; saturates at 15.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= 4'd0;
    end else if (if_gnt) begin
      starve_cnt_q <= 4'd0;
    end else if (issue && if_req && (sel_owner == OWN_DM) && (starve_cnt_q != 4'hF)) begin
      starve_cnt_q <= starve_cnt_q + 4'd1;
    end
  end
`else
  assign starve_force = 1'b0;
`endif

endmodule
